mem_port_arbiter: RTL and testbench

//  Shares one single-port synchronous block RAM (1-cycle read latency, byte-lane write enables)

---
 rtl/mem_port_arbiter.sv | 108 ++++++++++
 tb/tb_mem_port_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port synchronous RAM between the instruction-fetch and data ports.
// Data wins by default; a starvation counter hands instruction fetch one overriding grant.
module mem_port_arbiter #(
  parameter int unsigned RAM_AW     = 10,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req_i,
  input  logic [31:0]       inst_addr_i,
  output logic              inst_gnt_o,
  output logic              inst_rvalid_o,
  output logic [31:0]       inst_rdata_o,
  input  logic              data_req_i,
  input  logic              data_we_i,
  input  logic [3:0]        data_sel_i,
  input  logic [31:0]       data_addr_i,
  input  logic [31:0]       data_wdata_i,
  output logic              data_gnt_o,
  output logic              data_rvalid_o,
  output logic [31:0]       data_rdata_o,
  output logic              ram_en_o,
  output logic [3:0]        ram_we_o,
  output logic [RAM_AW-1:0] ram_addr_o,
  output logic [31:0]       ram_wdata_o,
  input  logic [31:0]       ram_rdata_i,
  output logic              stall_req_o
);

  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_INST = 2'd1,
    RD_DATA = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] starve_cnt;
  logic             starve_hit;
  logic [31:0]      inst_hold;
  logic [31:0]      data_hold;

  // Byte-offset and above-RAM address bits are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{inst_addr_i[31:RAM_AW+2], inst_addr_i[1:0],
                              data_addr_i[31:RAM_AW+2], data_addr_i[1:0]};

  assign starve_hit  = (starve_cnt == CNT_W'(STARVE_MAX));
  assign ram_wdata_o = data_wdata_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Grant, RAM drive, response and next outstanding-read state; everything quiet in reset.
  always_comb begin
    state_nxt     = IDLE;
    inst_gnt_o    = 1'b0;
    data_gnt_o    = 1'b0;
    inst_rvalid_o = 1'b0;
    data_rvalid_o = 1'b0;
    ram_we_o      = 4'b0000;
    ram_addr_o    = inst_addr_i[RAM_AW+1:2];
    stall_req_o   = 1'b0;
    if (rst) begin
      if (data_req_i && !(inst_req_i && starve_hit)) begin
        data_gnt_o = 1'b1;
        ram_addr_o = data_addr_i[RAM_AW+1:2];
        if (data_we_i) ram_we_o  = data_sel_i;
        else           state_nxt = RD_DATA;
      end else if (inst_req_i) begin
        inst_gnt_o = 1'b1;
        state_nxt  = RD_INST;
      end
      inst_rvalid_o = (state == RD_INST);
      data_rvalid_o = (state == RD_DATA);
      stall_req_o   = (inst_req_i && !inst_gnt_o) || (data_req_i && !data_gnt_o);
    end
    ram_en_o     = inst_gnt_o || data_gnt_o;
    inst_rdata_o = (state == RD_INST) ? ram_rdata_i : inst_hold;
    data_rdata_o = (state == RD_DATA) ? ram_rdata_i : data_hold;
  end

  // Counts consecutive denied fetch cycles; any fetch grant or dropped request clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (inst_req_i && !inst_gnt_o) begin
      if (!starve_hit) starve_cnt <= starve_cnt + CNT_W'(1);
    end else begin
      starve_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inst_hold <= '0;
      data_hold <= '0;
    end else begin
      if (state == RD_INST) inst_hold <= ram_rdata_i;
      if (state == RD_DATA) data_hold <= ram_rdata_i;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: behavioural RAM plus a transaction-level reference model,
// directed scenarios followed by randomized traffic with occasional resets.
module tb_mem_port_arbiter;

  localparam int unsigned RAM_AW     = 10;
  localparam int unsigned STARVE_MAX = 4;
  localparam int unsigned DEPTH      = 1 << RAM_AW;

  logic              clk = 1'b0;
  logic              rst;
  logic              inst_req_i;
  logic [31:0]       inst_addr_i;
  logic              inst_gnt_o;
  logic              inst_rvalid_o;
  logic [31:0]       inst_rdata_o;
  logic              data_req_i;
  logic              data_we_i;
  logic [3:0]        data_sel_i;
  logic [31:0]       data_addr_i;
  logic [31:0]       data_wdata_i;
  logic              data_gnt_o;
  logic              data_rvalid_o;
  logic [31:0]       data_rdata_o;
  logic              ram_en_o;
  logic [3:0]        ram_we_o;
  logic [RAM_AW-1:0] ram_addr_o;
  logic [31:0]       ram_wdata_o;
  logic [31:0]       ram_rdata_i;
  logic              stall_req_o;

  mem_port_arbiter #(.RAM_AW(RAM_AW), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .inst_req_i(inst_req_i), .inst_addr_i(inst_addr_i), .inst_gnt_o(inst_gnt_o),
    .inst_rvalid_o(inst_rvalid_o), .inst_rdata_o(inst_rdata_o),
    .data_req_i(data_req_i), .data_we_i(data_we_i), .data_sel_i(data_sel_i),
    .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
    .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
    .ram_en_o(ram_en_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
    .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i), .stall_req_o(stall_req_o)
  );

  always #5 clk = ~clk;

  // Behavioural RAM; read port shows garbage when not enabled so hold registers are exercised.
  logic [31:0] ram_mem [DEPTH];
  always @(posedge clk) begin
    if (ram_en_o) begin
      for (int b = 0; b < 4; b++)
        if (ram_we_o[b]) ram_mem[ram_addr_o][8*b +: 8] <= ram_wdata_o[8*b +: 8];
      ram_rdata_i <= ram_mem[ram_addr_o];
    end else begin
      ram_rdata_i <= $urandom;
    end
  end

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: independent memory image, pending response and starvation count.
  logic [31:0] model_mem [DEPTH];
  int          starve;
  int          pend;        // 0 none, 1 fetch response due, 2 data response due
  logic [31:0] pend_val;
  logic [31:0] ihold, dhold;
  logic        last_ign;

  function automatic logic [RAM_AW-1:0] widx(input logic [31:0] a);
    logic [31:0] w;
    w = a >> 2;
    return w[RAM_AW-1:0];
  endfunction

  task automatic model_reset();
    starve = 0; pend = 0; pend_val = '0; ihold = '0; dhold = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ign"},    32'(inst_gnt_o),    32'd0);
    check_eq({tag, "_dgn"},    32'(data_gnt_o),    32'd0);
    check_eq({tag, "_irv"},    32'(inst_rvalid_o), 32'd0);
    check_eq({tag, "_drv"},    32'(data_rvalid_o), 32'd0);
    check_eq({tag, "_en"},     32'(ram_en_o),      32'd0);
    check_eq({tag, "_we"},     32'(ram_we_o),      32'd0);
    check_eq({tag, "_stall"},  32'(stall_req_o),   32'd0);
    check_eq({tag, "_irdata"}, inst_rdata_o,       32'd0);
    check_eq({tag, "_drdata"}, data_rdata_o,       32'd0);
  endtask

  // Compare the current cycle against the model, then advance the model past the edge.
  task automatic model_step();
    logic exp_dg, exp_ig, exp_stall;
    logic [3:0] exp_we;
    logic [RAM_AW-1:0] a;
    exp_dg    = data_req_i && !(inst_req_i && starve >= STARVE_MAX);
    exp_ig    = inst_req_i && !exp_dg;
    exp_stall = (inst_req_i && !exp_ig) || (data_req_i && !exp_dg);
    exp_we    = (exp_dg && data_we_i) ? data_sel_i : 4'b0000;
    a         = exp_dg ? widx(data_addr_i) : widx(inst_addr_i);
    check_eq("dgn",   32'(data_gnt_o),    32'(exp_dg));
    check_eq("ign",   32'(inst_gnt_o),    32'(exp_ig));
    check_eq("stall", 32'(stall_req_o),   32'(exp_stall));
    check_eq("en",    32'(ram_en_o),      32'(exp_dg || exp_ig));
    check_eq("we",    32'(ram_we_o),      32'(exp_we));
    check_eq("irv",   32'(inst_rvalid_o), 32'(pend == 1));
    check_eq("drv",   32'(data_rvalid_o), 32'(pend == 2));
    check_eq("irdata", inst_rdata_o, (pend == 1) ? pend_val : ihold);
    check_eq("drdata", data_rdata_o, (pend == 2) ? pend_val : dhold);
    if (exp_dg || exp_ig) begin
      check_eq("addr",  32'(ram_addr_o), 32'(a));
      check_eq("wdata", ram_wdata_o,     data_wdata_i);
    end
    last_ign = inst_gnt_o;
    if (pend == 1) ihold = pend_val;
    if (pend == 2) dhold = pend_val;
    pend = 0;
    if (exp_ig || (exp_dg && !data_we_i)) begin
      pend     = exp_ig ? 1 : 2;
      pend_val = model_mem[a];
    end else if (exp_dg) begin
      for (int b = 0; b < 4; b++)
        if (data_sel_i[b]) model_mem[a][8*b +: 8] = data_wdata_i[8*b +: 8];
    end
    if (inst_req_i && !exp_ig) starve = (starve < STARVE_MAX) ? starve + 1 : STARVE_MAX;
    else                       starve = 0;
  endtask

  task automatic cycle(input logic ir, input logic [31:0] ia, input logic dr, input logic dwe,
                       input logic [3:0] dsel, input logic [31:0] da, input logic [31:0] dwd);
    @(negedge clk);
    inst_req_i = ir; inst_addr_i = ia;
    data_req_i = dr; data_we_i = dwe; data_sel_i = dsel; data_addr_i = da; data_wdata_i = dwd;
    #1;
    model_step();
  endtask

  task automatic idle();
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  // Reset asserted mid-traffic with requests active; released with requests low.
  task automatic reset_pulse(input string tag);
    @(negedge clk);
    rst = 1'b0; inst_req_i = 1'b1; data_req_i = 1'b1; data_we_i = 1'b1; data_sel_i = 4'hF;
    #1;
    model_reset();
    check_reset_outputs(tag);
    @(negedge clk);
    inst_req_i = 1'b0; data_req_i = 1'b0; data_we_i = 1'b0; data_sel_i = 4'h0;
    rst = 1'b1;
  endtask

  int first_ign;

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      ram_mem[i]   = (32'(i) * 32'h9E37_79B9) ^ 32'h0BAD_F00D;
      model_mem[i] = (32'(i) * 32'h9E37_79B9) ^ 32'h0BAD_F00D;
    end
    ram_mem[4]   = 32'h2402_0005;
    model_mem[4] = 32'h2402_0005;
    rst = 1'b0; inst_req_i = 1'b0; inst_addr_i = '0; data_req_i = 1'b0; data_we_i = 1'b0;
    data_sel_i = '0; data_addr_i = '0; data_wdata_i = '0;
    model_reset();
    last_ign = 1'b0;
    #1;
    check_reset_outputs("por");
    @(negedge clk);
    rst = 1'b1;

    // Single fetch, response next cycle, then the captured word must survive RAM output churn.
    cycle(1'b1, 32'h0000_0010, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    check_eq("t1_addr", 32'(ram_addr_o), 32'd4);
    idle();
    check_eq("t1_irdata", inst_rdata_o, 32'h2402_0005);
    idle();
    idle();
    check_eq("t6_hold", inst_rdata_o, 32'h2402_0005);

    // Fetch and data read together: data first, fetch next, both responses follow.
    cycle(1'b1, 32'h0000_0020, 1'b1, 1'b0, 4'h0, 32'h0000_0100, 32'h0);
    cycle(1'b1, 32'h0000_0020, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    idle();

    // Partial write, then read back the merged word.
    cycle(1'b0, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h0000_0008, 32'hDEAD_BEEF);
    check_eq("t3_addr", 32'(ram_addr_o), 32'd2);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h0000_0008, 32'h0);
    idle();

    // Data hogging the port: fetch must win on its fifth requesting cycle.
    first_ign = -1;
    for (int c = 0; c < 10; c++) begin
      cycle(1'b1, 32'h0000_0040, 1'b1, c[0], 4'hF, 32'(c * 4), $urandom);
      if (last_ign && first_ign < 0) first_ign = c;
    end
    check_eq("t4_first_ign", 32'(first_ign), 32'd4);
    idle();

    // Reset the cycle after a read grant: outstanding response is dropped.
    cycle(1'b1, 32'h0000_0010, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    reset_pulse("t5_rst");
    idle();
    check_eq("t5_irdata", inst_rdata_o, 32'd0);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        reset_pulse("rnd_rst");
      end else begin
        cycle($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
              4'($urandom_range(0, 15)), $urandom, $urandom);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
